// File: rtl/shifter_pkg.sv
// shifter_pkg: shared encodings for the multi-cycle right shifter
package shifter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SRL = 2'd0, SRA = 2'd1, ROR = 2'd2} mode_t;
  localparam int STEP_1 = 1;
  localparam int STEP_2 = 2;
  localparam int STEP_4 = 4;
  localparam int STEP_8 = 8;
  localparam int STEP_16 = 16;
  localparam int STEP_DEFAULT = STEP_4;
  function automatic bit legal_step(int s);
    return s inside {STEP_1, STEP_2, STEP_4, STEP_8, STEP_16};
  endfunction
  function automatic logic fill_bit(mode_t m, logic sign);
    return (m == SRA) & sign;
  endfunction
endpackage

// File: rtl/shr_step.sv
// shr_step: combinational right shift by k in 0..STEP with fill bit or rotate
// Ports: d operand, k shift amount (0..STEP), fill bit for vacated MSBs,
//        rot selects rotate (shifted-out bits re-enter at MSB), q result.
module shr_step #(
  parameter int STEP = 4
) (
  input  logic [31:0] d,
  input  logic [4:0]  k,
  input  logic        fill,
  input  logic        rot,
  output logic [31:0] q
);
  logic [63:0] ext;
  assign ext = {rot ? d : {32{fill}}, d};
  always_comb begin
    q = d;
    for (int i = 1; i <= STEP; i++) q = (k == 5'(i)) ? ext[i +: 32] : q;
  end
endmodule

// File: rtl/seq_shift_right.sv
// seq_shift_right: multi-cycle SRL/SRA (optional ROR) shifter, at most STEP bits per clock
// Ports: clock, reset (async, active-high); ctrl_shift start pulse taken in IDLE;
//        data_in/shamt/arith/op_rot operands captured at accept;
//        data_result (holds until next accept), data_resultRDY one-cycle valid pulse,
//        busy high from the cycle after accept through the RDY cycle.
// Macro SHR_ROTATE_EN: when defined, op_rot=1 selects rotate-right; otherwise op_rot is ignored.
module seq_shift_right
  import shifter_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  input  logic        op_rot,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);
  state_t state, nxt;
  mode_t mode, mode_in;
  logic [31:0] data, step_q;
  logic [4:0] rem, k;
  logic sign, rot;
  logic accept;
`ifdef SHR_ROTATE_EN
  assign mode_in = op_rot ? ROR : (arith ? SRA : SRL);
  assign rot = mode == ROR;
`else
  logic unused_rot;
  assign unused_rot = op_rot;
  assign mode_in = arith ? SRA : SRL;
  assign rot = 1'b0;
`endif
  assign accept = (state == IDLE) && ctrl_shift;
  // never shift further than what is left, so the last step may be short
  assign k = (rem > 5'(STEP)) ? 5'(STEP) : rem;
  shr_step #(.STEP(STEP)) u_step (
    .d(data),
    .k(k),
    .fill(fill_bit(mode, sign)),
    .rot(rot),
    .q(step_q)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE  ? (ctrl_shift ? (shamt == 5'd0 ? DONE : SHIFT) : IDLE) :
          state == SHIFT ? (rem == k ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data <= '0;
      rem  <= '0;
      sign <= 1'b0;
      mode <= SRL;
    end else if (accept) begin
      data <= data_in;
      rem  <= shamt;
      sign <= data_in[31];
      mode <= mode_in;
    end else if (state == SHIFT) begin
      data <= step_q;
      rem  <= rem - k;
    end
  end
  always_comb begin
    data_result    = data;
    busy           = state != IDLE;
    data_resultRDY = state == DONE;
  end
endmodule

// File: tb/tb_seq_shift_right.sv
// tb_seq_shift_right: randomized self-checking bench against a behavioural shift model
module tb_seq_shift_right;
  localparam int STEP = 4;
  localparam int WIN = 36;
  logic clock = 1'b0, reset = 1'b1, ctrl_shift = 1'b0, arith = 1'b0, op_rot = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0] shamt = '0;
  logic [31:0] data_result;
  logic data_resultRDY, busy;
  int n_cmp = 0, n_fail = 0;

  seq_shift_right #(.STEP(STEP)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_shift(ctrl_shift),
    .data_in(data_in),
    .shamt(shamt),
    .arith(arith),
    .op_rot(op_rot),
    .data_result(data_result),
    .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model(logic [31:0] d, int sh, bit ar, bit rot);
`ifdef SHR_ROTATE_EN
    if (rot) return sh == 0 ? d : (d >> sh) | (d << (32 - sh));
`endif
    if (ar) return 32'($signed(d) >>> sh);
    return d >> sh;
  endfunction

  function automatic int lat(int sh);
    return (sh + STEP - 1) / STEP + 1;
  endfunction

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic scramble;
    data_in = $urandom;
    shamt = 5'($urandom);
    arith = 1'($urandom);
    op_rot = 1'($urandom);
  endtask

  task automatic start_op(input logic [31:0] d, input int sh, input bit ar, input bit rot);
    data_in = d;
    shamt = 5'(sh);
    arith = ar;
    op_rot = rot;
    ctrl_shift = 1'b1;
    next_cycle;
    ctrl_shift = 1'b0;
    scramble;
  endtask

  task automatic observe(input int window, input int pulse_at, input bit stop_on_rdy,
                         output int rdy_cycle, output logic [31:0] res, output int pulses,
                         output int bfirst, output int blast, output int bcount);
    rdy_cycle = -1; res = '0; pulses = 0; bfirst = -1; blast = -1; bcount = 0;
    for (int c = 1; c <= window; c++) begin
      if (busy) begin
        if (bfirst < 0) bfirst = c;
        blast = c;
        bcount++;
      end
      if (data_resultRDY) begin
        pulses++;
        if (rdy_cycle < 0) begin
          rdy_cycle = c;
          res = data_result;
        end
        if (stop_on_rdy) return;
      end
      if (c == pulse_at) begin
        scramble;
        ctrl_shift = 1'b1;
      end else ctrl_shift = 1'b0;
      next_cycle;
    end
    ctrl_shift = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    scramble;
    ctrl_shift = 1'b1;
    next_cycle;
    next_cycle;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    n_cmp++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", data_result); end
    ctrl_shift = 1'b0;
    reset = 1'b0;
    next_cycle;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_vectors;
    logic [31:0] vd[6] = '{32'h80000000, 32'h80000000, 32'hF0F0F0F0, 32'h12345678, 32'hFFFF0000, 32'h7FFFFFFF};
    int vs[6] = '{31, 31, 4, 0, 16, 3};
    bit va[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ve[6] = '{32'hFFFFFFFF, 32'h00000001, 32'h0F0F0F0F, 32'h12345678, 32'hFFFFFFFF, 32'h0FFFFFFF};
    int rc, p, bf, bl, bc;
    logic [31:0] r;
    for (int i = 0; i < 6; i++) begin
      start_op(vd[i], vs[i], va[i], 1'b0);
      observe(WIN, 0, 1'b0, rc, r, p, bf, bl, bc);
      n_cmp++; if (r !== ve[i]) begin n_fail++; $display("FAIL vec%0d_result got %h want %h", i, r, ve[i]); end
      n_cmp++; if (rc !== lat(vs[i])) begin n_fail++; $display("FAIL vec%0d_rdy_cycle got %0d want %0d", i, rc, lat(vs[i])); end
      n_cmp++; if (p !== 1) begin n_fail++; $display("FAIL vec%0d_pulses got %0d want 1", i, p); end
      n_cmp++; if (bf !== 1 || bl !== lat(vs[i]) || bc !== lat(vs[i])) begin
        n_fail++; $display("FAIL vec%0d_busy got first=%0d last=%0d n=%0d want 1..%0d", i, bf, bl, bc, lat(vs[i]));
      end
      n_cmp++; if (data_result !== ve[i]) begin n_fail++; $display("FAIL vec%0d_hold got %h want %h", i, data_result, ve[i]); end
    end
  endtask

  task automatic test_random;
    logic [31:0] d, r, e;
    int sh, rc, p, bf, bl, bc;
    bit ar, rot;
    for (int i = 0; i < 30; i++) begin
      d = $urandom;
      sh = $urandom_range(0, 31);
      ar = 1'($urandom);
      rot = 1'($urandom);
      e = model(d, sh, ar, rot);
      start_op(d, sh, ar, rot);
      observe(WIN, 0, 1'b0, rc, r, p, bf, bl, bc);
      n_cmp++; if (r !== e || rc !== lat(sh) || p !== 1 || bc !== lat(sh)) begin
        n_fail++;
        $display("FAIL rand%0d d=%h sh=%0d ar=%0d rot=%0d got %h@%0d pulses=%0d busy=%0d want %h@%0d", i, d, sh, ar, rot, r, rc, p, bc, e, lat(sh));
      end
    end
  endtask

  task automatic test_busy_ignore;
    int rc, p, bf, bl, bc;
    logic [31:0] r;
    start_op(32'h80000000, 31, 1'b1, 1'b0);
    observe(WIN, 3, 1'b0, rc, r, p, bf, bl, bc);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL busy_start_result got %h want ffffffff", r); end
    n_cmp++; if (p !== 1 || bc !== lat(31)) begin n_fail++; $display("FAIL busy_start_queued got pulses=%0d busy=%0d want 1/%0d", p, bc, lat(31)); end
    start_op(32'hF0F0F0F0, 8, 1'b0, 1'b0);
    observe(WIN, lat(8), 1'b0, rc, r, p, bf, bl, bc);
    n_cmp++; if (r !== 32'h00F0F0F0) begin n_fail++; $display("FAIL done_start_result got %h want 00f0f0f0", r); end
    n_cmp++; if (p !== 1 || bc !== lat(8)) begin n_fail++; $display("FAIL done_start_queued got pulses=%0d busy=%0d want 1/%0d", p, bc, lat(8)); end
  endtask

  task automatic test_back_to_back;
    int rc, p, bf, bl, bc;
    logic [31:0] r;
    start_op(32'hA5A5A5A5, 7, 1'b1, 1'b0);
    observe(WIN, 0, 1'b1, rc, r, p, bf, bl, bc);
    n_cmp++; if (r !== 32'hFF4B4B4B || rc !== lat(7)) begin n_fail++; $display("FAIL b2b_first got %h@%0d want ff4b4b4b@%0d", r, rc, lat(7)); end
    next_cycle;
    start_op(32'h0000FFFF, 12, 1'b0, 1'b0);
    observe(WIN, 0, 1'b0, rc, r, p, bf, bl, bc);
    n_cmp++; if (r !== 32'h0000000F || rc !== lat(12) || p !== 1) begin
      n_fail++; $display("FAIL b2b_second got %h@%0d pulses=%0d want 0000000f@%0d", r, rc, p, lat(12));
    end
  endtask

  task automatic test_midreset;
    int rc, p, bf, bl, bc;
    logic [31:0] r;
    start_op(32'hDEADBEEF, 20, 1'b1, 1'b0);
    next_cycle;
    next_cycle;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'h0) begin
      n_fail++; $display("FAIL midreset_outputs got busy=%b rdy=%b result=%h want 0/0/0", busy, data_resultRDY, data_result);
    end
    next_cycle;
    reset = 1'b0;
    observe(20, 0, 1'b0, rc, r, p, bf, bl, bc);
    n_cmp++; if (p !== 0 || bc !== 0) begin n_fail++; $display("FAIL midreset_aborted got pulses=%0d busy=%0d want 0/0", p, bc); end
    start_op(32'hDEADBEEF, 20, 1'b1, 1'b0);
    observe(WIN, 0, 1'b0, rc, r, p, bf, bl, bc);
    n_cmp++; if (r !== 32'hFFFFFDEA || rc !== lat(20)) begin n_fail++; $display("FAIL midreset_next got %h@%0d want fffffdea@%0d", r, rc, lat(20)); end
  endtask

  task automatic test_rotate;
    int rc, p, bf, bl, bc;
    logic [31:0] r;
`ifdef SHR_ROTATE_EN
    start_op(32'h00000001, 1, 1'b0, 1'b1);
    observe(WIN, 0, 1'b0, rc, r, p, bf, bl, bc);
    n_cmp++; if (r !== 32'h80000000 || rc !== lat(1)) begin n_fail++; $display("FAIL ror1 got %h@%0d want 80000000@%0d", r, rc, lat(1)); end
    start_op(32'h12345678, 8, 1'b1, 1'b1);
    observe(WIN, 0, 1'b0, rc, r, p, bf, bl, bc);
    n_cmp++; if (r !== 32'h78123456 || rc !== lat(8)) begin n_fail++; $display("FAIL ror8 got %h@%0d want 78123456@%0d", r, rc, lat(8)); end
`else
    start_op(32'h80000001, 4, 1'b0, 1'b1);
    observe(WIN, 0, 1'b0, rc, r, p, bf, bl, bc);
    n_cmp++; if (r !== 32'h08000000 || rc !== lat(4)) begin n_fail++; $display("FAIL rot_ignored got %h@%0d want 08000000@%0d", r, rc, lat(4)); end
`endif
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_midreset;
    test_rotate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
